// File: rtl/aes_round_engine.sv
// -----------------------------------------------------------------------------
// aes_round_engine
//
// Iterative AES encryption datapath (AES-128/192/256 selected by NR).
// The 128-bit cipher state lives in one register. Each clock it passes through
// SubBytes, ShiftRows, MixColumns (skipped in the last round) and AddRoundKey,
// and the result is written back. Round keys come from an external key store
// addressed by round_idx, and must be valid in the same cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    plaintext block offered
//   in_ready    engine idle, block accepted when in_valid is also high
//   plaintext   input block, sampled only at the accepting edge
//   round_key   key for round round_idx (combinational from the key store)
//   round_idx   index of the round key needed this cycle, 0..NR
//   out_valid   ciphertext available, held until out_ready
//   out_ready   downstream accepts ciphertext
//   ciphertext  state register contents
//
// Byte order: bits [127:120] are s[0,0], [119:112] are s[1,0], column-major.
// -----------------------------------------------------------------------------
module aes_round_engine #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14, got %0d", NR);
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254 (square-and-multiply); 0 maps to 0,
  // which is exactly what the S-box definition needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = b;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box computed from its algebraic definition (inverse + affine map)
  // rather than stored as a table, so there is no constant to mistype.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------------
  // Round transforms
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Output (r,c) takes input (r,(c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c+0) -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c+0) -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      o[127-8*(4*c+3) -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  logic [127:0] sb_out;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] round_out;
  logic         last_round;

  assign sb_out     = sub_bytes(blk_q);
  assign sr_out     = shift_rows(sb_out);
  assign mc_out     = mix_columns(sr_out);
  assign last_round = (cnt_q == LAST_ROUND);
  assign round_out  = (last_round ? sr_out : mc_out) ^ round_key;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      blk_q <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    round_idx = cnt_q;
    case (fsm_q)
      IDLE: begin
        in_ready  = 1'b1;
        round_idx = 4'd0;
        if (in_valid) begin
          blk_d = plaintext ^ round_key;
          cnt_d = 4'd1;
          fsm_d = RUN;
        end
      end
      RUN: begin
        blk_d = round_out;
        // Counter saturates at the last round so it never exceeds NR.
        if (last_round) begin
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        round_idx = LAST_ROUND;
        if (out_ready) begin
          fsm_d = IDLE;
          cnt_d = 4'd0;
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  assign ciphertext = blk_q;

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES-128/192/256 encryption datapath. Holds the 128-bit cipher state in a register and runs one full round per clock.
- Each cycle, the state register drives the combinational SubBytes stage. This block consumes the SubBytes result and applies ShiftRows, MixColumns (skipped in the final round) and AddRoundKey, then writes the result back to the state register.
- Round keys come from an external key store, indexed by round_idx.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12, 14; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  engine idle and able to accept a block.
- plaintext  in  128  input block.
- round_key  in  128  key for round round_idx. Must be combinationally valid in the same cycle round_idx shows.
- round_idx  out  4  index of the round key currently required, 0..NR.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  downstream accepts ciphertext.
- ciphertext  out  128  result block; equals the state register.

Behaviour:
- Byte order: bits [127:120] are byte 0 = s[0,0], [119:112] = s[1,0], and so on, column-major per FIPS-197. SubBytes is applied to all 16 bytes in parallel.
- ShiftRows: row r is rotated left by r bytes. Output byte at (r,c) takes input (r,(c+r) mod 4).
- MixColumns: standard GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]. xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, round_idx=0, out_valid=0.
  - When in_valid is high at a clock edge: state <= plaintext ^ round_key (key 0), round counter <= 1, go to RUN.
- RUN:
  - in_ready=0, round_idx = counter.
  - Each edge: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), round_key), counter increments.
  - When counter==NR, MixColumns is bypassed and the next state is DONE.
- DONE:
  - out_valid=1, ciphertext held stable, round_idx=NR.
  - When out_ready is high at an edge, go to IDLE.
  - in_ready returns to 1 on the following cycle. No same-cycle handoff.
- Latency: the first out_valid cycle comes exactly NR edges after the accepting edge. Minimum block period is NR+2 cycles when out_ready is held high.
- in_valid is ignored outside IDLE. plaintext is sampled only at the accepting edge.
- Stalled output: out_valid stays high and ciphertext stays unchanged for any number of out_ready=0 cycles.
- Reset values (any time, including mid-round): state=0, counter=0, FSM=IDLE, in_ready=1, out_valid=0, round_idx=0, ciphertext=0. The in-flight block is discarded with no output.
- Counter is 4 bits. It never exceeds NR and never wraps.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, round keys supplied by the bench model.
  - Required: state after the accept edge = 193de3bea0f4e22b9ac68d2ae9f84808; after round 1 = a49c7ff2689f352b6b5bea43026a5049; ciphertext = 3925841d02dc09fbdc118597196a0b32 with out_valid exactly 10 edges after accept.
- FIPS-197 App. C.1 (NR=10):
  - Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: ciphertext = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. C.3 (NR=14):
  - Stimulus: same plaintext, key 000102…1e1f.
  - Required: ciphertext = 8ea2b7ca516745bfeafc49904b496089, out_valid 14 edges after accept; round_idx sequence 0,1,…,14.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid; toggle in_valid and plaintext during RUN and DONE.
  - Required: ciphertext stable, in_ready=0 throughout, no second block accepted; in_ready=1 one cycle after the out_ready handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously at round 5, release, then send the App. C.1 block.
  - Required: all outputs are 0 immediately (in_ready=1), and the correct ciphertext arrives after a clean 10-round latency.
- Back-to-back:
  - Stimulus: out_ready=1 and in_valid=1 continuously, App. B block then App. C.1 block.
  - Required: both correct ciphertexts, accepting edges 12 cycles apart.
